// File: rtl/eyeriss_pe_dispatch_scheduler.sv
// Purpose: per-pass scheduler between the GLB and a row of PEs. It broadcasts the config word, arbitrates filter/ifmap/psum onto the ID-tagged bus, then runs the PE stall/ready handshake.
// Latency: a grant in cycle k puts getdata_*/data_out/id_out on the bus in cycle k+1. conf_o is registered at the end of CONF.
// Backpressure: a stream is acked only in LOAD, while its valid is high and its count is below target. Each cycle grants at most one word, chosen round-robin.
//
// Ports:
//   CLK, Rst                 rising-edge clock, synchronous active-high reset
//   start, cfg_*             pass request; the config word and word counts are latched when start is accepted in IDLE
//   {fil,map,psum}_valid/_data/_id/_ack   GLB request streams; a word transfers when valid and ack are both high
//   pe_ready                 ready outputs of the PEs
//   data_out, id_out, getdata_*           registered PE write bus
//   conf_o                   registered PE config word, with the enable bit forced high for the whole pass
//   stall, busy, done        PE stall, pass-in-progress flag, one-cycle pass-complete pulse
module eyeriss_pe_dispatch_scheduler #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 8
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              start,
    input  logic [25:0]       cfg_conf,
    input  logic [7:0]        cfg_fil_words,
    input  logic [7:0]        cfg_map_words,
    input  logic [7:0]        cfg_psum_words,
    input  logic              fil_valid,
    input  logic              map_valid,
    input  logic              psum_valid,
    input  logic [DATA_W-1:0] fil_data,
    input  logic [DATA_W-1:0] map_data,
    input  logic [DATA_W-1:0] psum_data,
    input  logic [ID_W-1:0]   fil_id,
    input  logic [ID_W-1:0]   map_id,
    input  logic [ID_W-1:0]   psum_id,
    output logic              fil_ack,
    output logic              map_ack,
    output logic              psum_ack,
    input  logic [NUM_PE-1:0] pe_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [ID_W-1:0]   id_out,
    output logic              getdata_fil,
    output logic              getdata_map,
    output logic              getdata_psum,
    output logic [25:0]       conf_o,
    output logic              stall,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONF, S_LOAD, S_FLUSH, S_RUN_BUSY, S_RUN_DRAIN, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [25:0]          cfg_q, cfg_d;
    logic [2:0][7:0]      tgt_q, tgt_d;
    logic [2:0][7:0]      cnt_q, cnt_d;
    logic [1:0]           ptr_q, ptr_d;        // stream index searched first: 0 fil, 1 map, 2 psum
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic [ID_W-1:0]      id_out_q, id_out_d;
    logic [2:0]           getdata_q, getdata_d;
    logic [25:0]          conf_o_q, conf_o_d;

    logic [2:0]           elig;
    logic [2:0]           grant;
    logic [1:0]           gsel;
    logic                 hit;
    logic [2:0]           rr_idx;
    logic                 all_done;
    logic [DATA_W-1:0]    sel_data;
    logic [ID_W-1:0]      sel_id;

    // A stream is eligible while it has words left to send in this pass.
    assign elig[0] = (state_q == S_LOAD) && fil_valid  && (cnt_q[0] < tgt_q[0]);
    assign elig[1] = (state_q == S_LOAD) && map_valid  && (cnt_q[1] < tgt_q[1]);
    assign elig[2] = (state_q == S_LOAD) && psum_valid && (cnt_q[2] < tgt_q[2]);

    // Round-robin search, starting at ptr_q and wrapping modulo 3.
    always_comb begin
        grant  = 3'b000;
        gsel   = 2'd0;
        hit    = 1'b0;
        rr_idx = 3'd0;
        for (int k = 0; k < 3; k++) begin
            rr_idx = {1'b0, ptr_q} + 3'(k);
            if (rr_idx >= 3'd3) begin
                rr_idx = rr_idx - 3'd3;
            end
            if (!hit && elig[rr_idx[1:0]]) begin
                hit  = 1'b1;
                gsel = rr_idx[1:0];
            end
        end
        if (hit) begin
            grant[gsel] = 1'b1;
        end
    end

    always_comb begin
        sel_data = fil_data;
        sel_id   = fil_id;
        case (gsel)
            2'd1:    begin sel_data = map_data;  sel_id = map_id;  end
            2'd2:    begin sel_data = psum_data; sel_id = psum_id; end
            default: begin sel_data = fil_data;  sel_id = fil_id;  end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        tgt_d      = tgt_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        id_out_d   = id_out_q;
        getdata_d  = 3'b000;
        conf_o_d   = conf_o_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i] + {7'd0, grant[i]};
        end

        if (hit) begin
            getdata_d  = grant;
            data_out_d = sel_data;
            id_out_d   = sel_id;
            ptr_d      = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
        end

        // Completion includes the grant made in this cycle.
        all_done = (cnt_d[0] == tgt_q[0]) && (cnt_d[1] == tgt_q[1]) && (cnt_d[2] == tgt_q[2]);

        case (state_q)
            S_IDLE: begin
                conf_o_d = 26'd0;
                if (start) begin
                    state_d = S_CONF;
                    cfg_d   = cfg_conf;
                    tgt_d   = {cfg_psum_words, cfg_map_words, cfg_fil_words};
                    cnt_d   = '0;
                    ptr_d   = 2'd0;
                end
            end
            S_CONF: begin
                // Force the PE enable bit high for the duration of the pass.
                conf_o_d = cfg_q | 26'h200_0000;
                state_d  = S_LOAD;
            end
            S_LOAD:      if (all_done)   state_d = S_FLUSH;
            S_FLUSH:     state_d = S_RUN_BUSY;
            S_RUN_BUSY:  if (!(&pe_ready)) state_d = S_RUN_DRAIN;
            S_RUN_DRAIN: if (&pe_ready)    state_d = S_DONE;
            S_DONE: begin
                // Clear conf_o on the way out so it is 0 for the whole time in IDLE.
                conf_o_d = 26'd0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= 2'd0;
            data_out_q <= '0;
            id_out_q   <= '0;
            getdata_q  <= 3'b000;
            conf_o_q   <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            id_out_q   <= id_out_d;
            getdata_q  <= getdata_d;
            conf_o_q   <= conf_o_d;
        end
    end

    assign fil_ack      = grant[0];
    assign map_ack      = grant[1];
    assign psum_ack     = grant[2];
    assign data_out     = data_out_q;
    assign id_out       = id_out_q;
    assign getdata_fil  = getdata_q[0];
    assign getdata_map  = getdata_q[1];
    assign getdata_psum = getdata_q[2];
    assign conf_o       = conf_o_q;
    assign stall        = !((state_q == S_RUN_BUSY) || (state_q == S_RUN_DRAIN));
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule
